mac_operand_packer: RTL and testbench
=====================================

# mac_operand_packer

Upstream feeder for the reconfigurable MAC decode stage. Accepts one operand pair per cycle from a stream and packs pairs into the 24-bit A/B words (plus 16-bit C) in the lane layout the decoder expects for each precision mode. Presents each packed word with a valid/ready handshake and a lane mask, so partial words at a stream end are explicitly marked.

## Interface
- No parameters. Widths are fixed by the MAC datapath.
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- cfg_mode  in  2  precision: 00 BF16 (1 lane), 01 FP8 (3 lanes), 10 FP4 (6 lanes), 11 INT4 (6 lanes); sampled only on the first element of a word
- in_valid  in  1  operand pair valid
- in_ready  out  1  packer accepts pair this cycle
- in_a, in_b  in  16  operand; BF16 uses [15:0], FP8 uses [7:0], FP4/INT4 use [3:0]; upper bits ignored
- in_c  in  16  addend; captured with the first element of each word
- in_last  in  1  final element of the stream; forces emission of the current word
- out_valid  out  1  packed word valid
- out_ready  in  1  consumer accepts word
- A, B  out  24  packed operand words
- C  out  16  captured addend
- mode  out  2  mode latched for this word
- lane_mask  out  6  bit k set = lane k holds real data; lane 0 is the most significant lane

## Operation
- Lane layout, lane 0 first:
  - Mode 00: lane 0 = [15:0]; [23:16] = 0.
  - Mode 01: lanes 0/1/2 = [23:16]/[15:8]/[7:0].
  - Modes 10/11: lanes 0..5 = [23:20]/[19:16]/[15:12]/[11:8]/[7:4]/[3:0].
- Lane count N: 1 for mode 00, 3 for mode 01, 6 for modes 10 and 11.
- FSM states:
  - FILL: accepting pairs; lane counter cnt (3 bits) runs 0..N-1.
  - FULL: word held; out_valid = 1.
- Accepted pair at cnt = 0:
  - Clear A/B staging to zero.
  - Latch cfg_mode into mode and in_c into C.
  - Write lane 0; set lane_mask = 000001 (bit 0 only).
- Accepted pair at cnt > 0: write lane cnt; set lane_mask[cnt]. cfg_mode and in_c are ignored.
- Transition to FULL when the accepted pair has cnt = N-1 or in_last = 1; cnt resets to 0. Unfilled lanes stay zero with their mask bits clear.
- FULL with out_ready = 1: the word retires.
  - If in_valid is also 1, that pair is accepted as cnt = 0 of the next word in the same cycle. State stays FULL if this completes the word (N = 1, or in_last), otherwise it goes to FILL.
  - Otherwise go to FILL.
- in_ready = (state == FILL) || out_ready.
- Outputs A, B, C, mode and lane_mask stay stable while out_valid = 1 and out_ready = 0.
- Changing cfg_mode mid-word has no effect until the next cnt = 0 acceptance.

## Timing
- Reset values (rst_n low at a clock edge): state FILL, cnt 0, out_valid 0, A/B 0, C 0, mode 00, lane_mask 0. in_ready = 1 from the first cycle after reset.
- Reset mid-word or mid-hold discards the partial or held word; nothing is emitted afterwards.
- Latency: out_valid rises the cycle after the completing pair is accepted.
- Throughput: one pair per cycle sustained in every mode, given out_ready = 1. Mode 00 therefore emits one word per cycle.
- No combinational path from in_* to out_*. in_ready depends combinationally on out_ready only.

## Structure
- Shared package holds:
  - mode enum: MODE_BF16, MODE_FP8, MODE_FP4, MODE_INT4.
  - Function lanes_for_mode(mode) returning 1/3/6.
  - Lane width and bit-offset constants. The decoder uses the same constants.
- One natural sub-module, `lane_inserter`: combinational; takes the staging word, lane index, mode and element, and returns the updated word. One instance each for A and B.
- FSM, counter, mask and C/mode latches live in the top.

## Test plan
- Mode 01, out_ready = 1, pairs a = 0x3C, 0x41, 0x7F and b = 0x38, 0x40, 0x01 → A = 0x3C417F, B = 0x384001, lane_mask = 000111, out_valid for 1 cycle.
- Mode 10, six pairs a = 1..6, b = 0xF..0xA → A = 0x123456, B = 0xFEDCBA, mask = 111111.
- Mode 11, two pairs a = 0x9, 0x2 with in_last on the second → A = 0x920000, mask = 000011.
- Mode 00, continuous in_valid, out_ready = 1: a = 0x3F80, 0x4000; c = 0x4040, 0x0000 → back-to-back words A = 0x003F80 then 0x004000, each with the C sampled with it; in_ready stays 1.
- Backpressure, mode 01: out_ready = 0 for 5 cycles after word completes → outputs frozen, in_ready = 0. Release with in_valid = 1 → new pair accepted in the same cycle as the retire.
- Mode 10, rst_n low after 4 pairs → out_valid = 0, mask = 0. The next 6 pairs form a clean word with no stale lanes.

Source files
------------

// File: rtl/mac_operand_packer_pkg.sv
// Shared types and lane geometry for the MAC operand packer and the decode stage.
// Lane 0 is the most significant lane of each 24-bit word.
package mac_operand_packer_pkg;

  typedef enum logic [1:0] {
    MODE_BF16 = 2'b00,
    MODE_FP8  = 2'b01,
    MODE_FP4  = 2'b10,
    MODE_INT4 = 2'b11
  } mode_e;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  localparam int unsigned WORD_W    = 24;
  localparam int unsigned ELEM_W    = 16;
  localparam int unsigned C_W       = 16;
  localparam int unsigned MAX_LANES = 6;

  localparam int unsigned BF16_LANE_W = 16;
  localparam int unsigned FP8_LANE_W  = 8;
  localparam int unsigned FP4_LANE_W  = 4;

  // Bit offset of lane 0; lane k sits k lane-widths below it.
  localparam int unsigned BF16_LANE0_OFF = 0;
  localparam int unsigned FP8_LANE0_OFF  = 16;
  localparam int unsigned FP4_LANE0_OFF  = 20;

  function automatic logic [2:0] lanes_for_mode(input mode_e m);
    case (m)
      MODE_BF16: return 3'd1;
      MODE_FP8:  return 3'd3;
      default:   return 3'd6;
    endcase
  endfunction

endpackage

// File: rtl/mac_operand_packer_if.sv
// Operand stream in / packed word out bundle for the MAC operand packer.
// slave = packer side, master = producer/consumer side.
interface mac_operand_packer_if;
  import mac_operand_packer_pkg::*;

  logic [1:0]         cfg_mode;
  logic               in_valid;
  logic               in_ready;
  logic [ELEM_W-1:0]  in_a;
  logic [ELEM_W-1:0]  in_b;
  logic [C_W-1:0]     in_c;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [WORD_W-1:0]  A;
  logic [WORD_W-1:0]  B;
  logic [C_W-1:0]     C;
  logic [1:0]         mode;
  logic [MAX_LANES-1:0] lane_mask;

  modport slave (
    input  cfg_mode, in_valid, in_a, in_b, in_c, in_last, out_ready,
    output in_ready, out_valid, A, B, C, mode, lane_mask
  );

  modport master (
    output cfg_mode, in_valid, in_a, in_b, in_c, in_last, out_ready,
    input  in_ready, out_valid, A, B, C, mode, lane_mask
  );
endinterface

// File: rtl/mac_operand_packer_lane_inserter.sv
// Combinational lane write: places one element into the selected lane of a
// staging word according to the precision mode.
module lane_inserter
  import mac_operand_packer_pkg::*;
(
  input  logic [WORD_W-1:0] word_in,
  input  logic [2:0]        lane,
  input  mode_e             mode,
  input  logic [ELEM_W-1:0] elem,
  output logic [WORD_W-1:0] word_out
);

  always_comb begin
    word_out = word_in;
    case (mode)
      MODE_BF16: begin
        if (lane == 3'd0)
          word_out[BF16_LANE0_OFF +: BF16_LANE_W] = elem[BF16_LANE_W-1:0];
      end
      MODE_FP8: begin
        for (int unsigned k = 0; k < 3; k++) begin
          if (32'(lane) == k)
            word_out[FP8_LANE0_OFF - k*FP8_LANE_W +: FP8_LANE_W] = elem[FP8_LANE_W-1:0];
        end
      end
      default: begin
        for (int unsigned k = 0; k < MAX_LANES; k++) begin
          if (32'(lane) == k)
            word_out[FP4_LANE0_OFF - k*FP4_LANE_W +: FP4_LANE_W] = elem[FP4_LANE_W-1:0];
        end
      end
    endcase
  end

endmodule

// File: rtl/mac_operand_packer.sv
// Packs a stream of operand pairs into 24-bit A/B lane words (plus addend C)
// for the reconfigurable MAC decoder, with a valid/ready output and lane mask.
module mac_operand_packer
  import mac_operand_packer_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  mac_operand_packer_if.slave bus
);

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [WORD_W-1:0]    a_q, a_d, b_q, b_d;
  logic [C_W-1:0]       c_q, c_d;
  mode_e                mode_q, mode_d;
  logic [MAX_LANES-1:0] mask_q, mask_d;

  logic                 in_ready;
  logic                 accept;
  logic                 first;
  mode_e                eff_mode;
  logic [WORD_W-1:0]    a_base, b_base, a_ins, b_ins;

  // In FULL the counter is already 0, so an accept during retire is a first element.
  always_comb begin
    in_ready = (state_q == ST_FILL) || bus.out_ready;
    accept   = bus.in_valid && in_ready;
    first    = (cnt_q == 3'd0);
    eff_mode = first ? mode_e'(bus.cfg_mode) : mode_q;
    a_base   = first ? '0 : a_q;
    b_base   = first ? '0 : b_q;
  end

  lane_inserter u_ins_a (
    .word_in  (a_base),
    .lane     (cnt_q),
    .mode     (eff_mode),
    .elem     (bus.in_a),
    .word_out (a_ins)
  );

  lane_inserter u_ins_b (
    .word_in  (b_base),
    .lane     (cnt_q),
    .mode     (eff_mode),
    .elem     (bus.in_b),
    .word_out (b_ins)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    mode_d  = mode_q;
    mask_d  = mask_q;

    if (accept) begin
      a_d = a_ins;
      b_d = b_ins;
      if (first) begin
        mode_d = eff_mode;
        c_d    = bus.in_c;
        mask_d = 6'b000001;
      end else begin
        mask_d = mask_q | (6'b000001 << cnt_q);
      end

      if ((cnt_q == lanes_for_mode(eff_mode) - 3'd1) || bus.in_last) begin
        cnt_d   = '0;
        state_d = ST_FULL;
      end else begin
        cnt_d   = cnt_q + 3'd1;
        state_d = ST_FILL;
      end
    end else if (state_q == ST_FULL && bus.out_ready) begin
      state_d = ST_FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      mode_q  <= MODE_BF16;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.C         = c_q;
  assign bus.mode      = mode_q;
  assign bus.lane_mask = mask_q;

endmodule

// File: tb/tb_mac_operand_packer.sv
// Self-checking bench for mac_operand_packer: directed scenarios plus random
// traffic, compared against a word-level reference model.
module tb_mac_operand_packer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mac_operand_packer_if bus ();

  mac_operand_packer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: held word, partially collected pairs.
  logic        m_full;
  logic        m_just_reset;
  logic [23:0] h_a, h_b;
  logic [15:0] h_c;
  logic [1:0]  h_mode;
  logic [5:0]  h_mask;
  logic [15:0] pa [6];
  logic [15:0] pb [6];
  int          pn;
  logic [1:0]  p_mode;
  logic [15:0] p_c;

  function automatic int n_lanes(input logic [1:0] md);
    return (md == 2'd0) ? 1 : (md == 2'd1) ? 3 : 6;
  endfunction

  function automatic logic [23:0] pack_word(input logic [1:0] md, input logic [15:0] v [6], input int n);
    logic [23:0] w;
    w = 24'h0;
    for (int k = 0; k < n; k++) begin
      if (md == 2'd0)      w = {8'h00, v[0]};
      else if (md == 2'd1) w = w | (24'(v[k][7:0]) << (16 - 8*k));
      else                 w = w | (24'(v[k][3:0]) << (20 - 4*k));
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One cycle: drive inputs (called at negedge), check outputs, advance model at the edge.
  task automatic tick(input logic rst, input logic iv, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic last, input logic [1:0] cfg, input logic ordy);
    logic exp_ready, retire, acc;
    rst_n         = ~rst;
    bus.in_valid  = iv;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_c      = c;
    bus.in_last   = last;
    bus.cfg_mode  = cfg;
    bus.out_ready = ordy;
    #1;
    exp_ready = !m_full || ordy;
    chk("in_ready", 24'(bus.in_ready), 24'(exp_ready));
    chk("out_valid", 24'(bus.out_valid), 24'(m_full));
    if (m_full) begin
      chk("A", bus.A, h_a);
      chk("B", bus.B, h_b);
      chk("C", 24'(bus.C), 24'(h_c));
      chk("mode", 24'(bus.mode), 24'(h_mode));
      chk("lane_mask", 24'(bus.lane_mask), 24'(h_mask));
    end
    if (m_just_reset) begin
      chk("rst_A", bus.A, 24'h0);
      chk("rst_B", bus.B, 24'h0);
      chk("rst_C", 24'(bus.C), 24'h0);
      chk("rst_mode", 24'(bus.mode), 24'h0);
      chk("rst_mask", 24'(bus.lane_mask), 24'h0);
    end
    retire = m_full && ordy;
    acc    = iv && exp_ready;
    if (rst) begin
      m_full       = 1'b0;
      pn           = 0;
      m_just_reset = 1'b1;
    end else begin
      m_just_reset = 1'b0;
      if (retire) m_full = 1'b0;
      if (acc) begin
        if (pn == 0) begin
          p_mode = cfg;
          p_c    = c;
        end
        pa[pn] = a;
        pb[pn] = b;
        pn++;
        if (pn == n_lanes(p_mode) || last) begin
          h_a    = pack_word(p_mode, pa, pn);
          h_b    = pack_word(p_mode, pb, pn);
          h_c    = p_c;
          h_mode = p_mode;
          h_mask = 6'((1 << pn) - 1);
          m_full = 1'b1;
          pn     = 0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    m_full = 1'b0; m_just_reset = 1'b0; pn = 0;
    h_a = '0; h_b = '0; h_c = '0; h_mode = '0; h_mask = '0; p_mode = '0; p_c = '0;
    for (int i = 0; i < 6; i++) begin pa[i] = '0; pb[i] = '0; end
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_c = '0;
    bus.in_last = 1'b0; bus.cfg_mode = 2'd0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_just_reset = 1'b1;

    // FP8 word of three pairs
    tick(0, 1, 16'h003C, 16'h0038, 16'h1234, 0, 2'd1, 1);
    tick(0, 1, 16'h0041, 16'h0040, 16'h0000, 0, 2'd2, 1);
    tick(0, 1, 16'h007F, 16'h0001, 16'h0000, 0, 2'd0, 1);
    chk("tp_fp8_A", bus.A, 24'h3C417F);
    chk("tp_fp8_B", bus.B, 24'h384001);
    chk("tp_fp8_mask", 24'(bus.lane_mask), 24'h000007);
    tick(0, 0, 16'h0, 16'h0, 16'h0, 0, 2'd1, 1);

    // FP4 word of six pairs
    for (int i = 0; i < 6; i++)
      tick(0, 1, 16'(i + 1), 16'(15 - i), 16'hBEEF, 0, 2'd2, 1);
    chk("tp_fp4_A", bus.A, 24'h123456);
    chk("tp_fp4_B", bus.B, 24'hFEDCBA);
    tick(0, 0, 16'h0, 16'h0, 16'h0, 0, 2'd2, 1);

    // INT4 short word ended by in_last
    tick(0, 1, 16'hFFF9, 16'h0003, 16'h0042, 0, 2'd3, 1);
    tick(0, 1, 16'h0002, 16'h0004, 16'h0000, 1, 2'd3, 1);
    chk("tp_int4_A", bus.A, 24'h920000);
    chk("tp_int4_mask", 24'(bus.lane_mask), 24'h000003);

    // BF16 back-to-back words
    tick(0, 1, 16'h3F80, 16'h1111, 16'h4040, 0, 2'd0, 1);
    chk("tp_bf16_A0", bus.A, 24'h003F80);
    chk("tp_bf16_C0", 24'(bus.C), 24'h004040);
    tick(0, 1, 16'h4000, 16'h2222, 16'h0000, 0, 2'd0, 1);
    chk("tp_bf16_A1", bus.A, 24'h004000);
    chk("tp_bf16_C1", 24'(bus.C), 24'h000000);
    tick(0, 0, 16'h0, 16'h0, 16'h0, 0, 2'd0, 1);

    // FP8 backpressure, then release with a pair accepted on the retire cycle
    for (int i = 0; i < 3; i++)
      tick(0, 1, 16'($urandom), 16'($urandom), 16'($urandom), 0, 2'd1, 1);
    for (int i = 0; i < 5; i++)
      tick(0, 1, 16'($urandom), 16'($urandom), 16'($urandom), 0, 2'($urandom), 0);
    for (int i = 0; i < 3; i++)
      tick(0, 1, 16'($urandom), 16'($urandom), 16'($urandom), 0, 2'd1, 1);
    tick(0, 0, 16'h0, 16'h0, 16'h0, 0, 2'd1, 1);

    // FP4 reset mid-word, then a clean word
    for (int i = 0; i < 4; i++)
      tick(0, 1, 16'($urandom), 16'($urandom), 16'($urandom), 0, 2'd2, 1);
    tick(1, 0, 16'h0, 16'h0, 16'h0, 0, 2'd2, 1);
    for (int i = 0; i < 6; i++)
      tick(0, 1, 16'($urandom), 16'($urandom), 16'($urandom), 0, 2'd2, 1);
    tick(0, 0, 16'h0, 16'h0, 16'h0, 0, 2'd2, 1);

    // Random traffic
    for (int i = 0; i < 600; i++)
      tick(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
           16'($urandom), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 4) == 0), 2'($urandom), ($urandom_range(0, 2) != 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
